// File: rtl/sort4_stream.sv
// sort4_stream: serial 4-element stable sorter using an odd-even transposition network.
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     input handshake, in_data element to load
//   out_valid/out_ready   output handshake, out_data sorted element, out_idx its arrival position
//   busy                  high while sorting or emitting
module sort4_stream #(
  parameter int WIDTH   = 8,
  parameter int DESCEND = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_idx,
  output logic             busy
);
  typedef enum logic [1:0] {LOAD, SORT, EMIT} state_t;
  state_t state, state_nxt;
  logic [WIDTH-1:0] data [4];
  logic [1:0]       idx  [4];
  logic [WIDTH-1:0] sd   [4];
  logic [1:0]       si   [4];
  logic [1:0]       cnt, phase;
  logic             in_fire, out_fire;
  function automatic logic out_of_order(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    return (DESCEND != 0) ? (a < b) : (a > b);
  endfunction
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= LOAD;
    else        state <= state_nxt;
  always_comb
    state_nxt = (state == LOAD && in_fire && cnt == 2'd3)  ? SORT :
                (state == SORT && phase == 2'd3)           ? EMIT :
                (state == EMIT && out_fire && cnt == 2'd3) ? LOAD : state;
  always_comb begin
    in_ready  = (state == LOAD);
    out_valid = (state == EMIT);
    busy      = (state != LOAD);
    out_data  = out_valid ? data[cnt] : '0;
    out_idx   = out_valid ? idx[cnt]  : 2'd0;
  end
  // Pair k compares entries k and k+1; even phases use k=0,2, odd phases k=1.
  // Strict compare keeps equal keys in arrival order.
  always_comb begin
    sd = data;
    si = idx;
    for (int k = 0; k < 3; k++)
      if (k[0] == phase[0] && out_of_order(data[k], data[k+1])) begin
        sd[k]   = data[k+1];
        sd[k+1] = data[k];
        si[k]   = idx[k+1];
        si[k+1] = idx[k];
      end
  end
  // cnt and phase wrap naturally from 3 to 0 on the final beat of each stage.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt   <= 2'd0;
      phase <= 2'd0;
      for (int k = 0; k < 4; k++) begin
        data[k] <= '0;
        idx[k]  <= 2'd0;
      end
    end else if (state == LOAD) begin
      phase <= 2'd0;
      if (in_fire) begin
        data[cnt] <= in_data;
        idx[cnt]  <= cnt;
        cnt       <= cnt + 2'd1;
      end
    end else if (state == SORT) begin
      data  <= sd;
      idx   <= si;
      phase <= phase + 2'd1;
    end else if (out_fire) begin
      cnt <= cnt + 2'd1;
    end
endmodule

// File: tb/tb_sort4_stream.sv
// tb_sort4_stream: scoreboard bench for ascending and descending sort4_stream instances.
module tb_sort4_stream;
  logic       clk = 0, rst_n = 0;
  logic       in_valid0 = 0, in_valid1 = 0, out_ready0 = 1, out_ready1 = 1;
  logic [7:0] in_data0 = 0, in_data1 = 0;
  logic       in_ready0, in_ready1, out_valid0, out_valid1, busy0, busy1;
  logic [7:0] out_data0, out_data1;
  logic [1:0] out_idx0, out_idx1;
  logic [9:0] q0 [$];
  logic [9:0] q1 [$];
  int         checks = 0, failures = 0;
  logic       stall_en = 0, held_v0 = 0;
  logic [9:0] held0;
  always #5 clk = ~clk;
  sort4_stream #(.WIDTH(8), .DESCEND(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0), .out_idx(out_idx0), .busy(busy0));
  sort4_stream #(.WIDTH(8), .DESCEND(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1), .out_idx(out_idx1), .busy(busy1));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  always @(negedge clk) if (rst_n) begin
    if (busy0) chk("in_ready_busy0", 32'(in_ready0), 0);
    if (held_v0 && out_valid0) chk("hold0", 32'({out_data0, out_idx0}), 32'(held0));
    if (out_valid0 && out_ready0) begin
      if (q0.size() == 0) chk("unexpected_beat0", 32'({out_data0, out_idx0}), 32'h3ff);
      else chk("beat0", 32'({out_data0, out_idx0}), 32'(q0.pop_front()));
    end
    held_v0 = out_valid0 && !out_ready0;
    held0   = {out_data0, out_idx0};
    if (out_valid1 && out_ready1) begin
      if (q1.size() == 0) chk("unexpected_beat1", 32'({out_data1, out_idx1}), 32'h3ff);
      else chk("beat1", 32'({out_data1, out_idx1}), 32'(q1.pop_front()));
    end
  end
  initial forever begin
    @(posedge clk);
    #2;
    out_ready0 = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end
  task automatic send(input bit sel, input logic [7:0] v, input int gap);
    int t;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    if (sel) begin in_valid1 = 1; in_data1 = v; end
    else     begin in_valid0 = 1; in_data0 = v; end
    t = 0;
    while (!(sel ? in_ready1 : in_ready0) && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) chk("in_ready_timeout", 32'(t), 0);
    @(posedge clk);
    #1;
    in_valid0 = 0;
    in_valid1 = 0;
  endtask
  task automatic group(input bit sel, input logic [31:0] vals, input logic [39:0] exp, input bit rnd_gap);
    for (int i = 0; i < 4; i++)
      if (sel) q1.push_back(exp[39-10*i -: 10]); else q0.push_back(exp[39-10*i -: 10]);
    for (int i = 0; i < 4; i++) send(sel, vals[31-8*i -: 8], rnd_gap ? $urandom_range(0, 3) : 0);
  endtask
  task automatic drain;
    int t = 0;
    while ((q0.size() != 0 || q1.size() != 0 || busy0 || busy1) && t < 300) begin @(negedge clk); t++; end
    if (t >= 300) chk("drain_timeout", 32'(t), 0);
  endtask
  initial begin
    int e;
    #1;
    chk("rst_in_ready", 32'(in_ready0), 1);
    chk("rst_out_valid", 32'(out_valid0), 0);
    chk("rst_busy", 32'(busy0), 0);
    chk("rst_out_data", 32'({out_data0, out_idx0}), 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    group(0, {8'd4, 8'd3, 8'd2, 8'd1}, {8'd1, 2'd3, 8'd2, 2'd2, 8'd3, 2'd1, 8'd4, 2'd0}, 0);
    e = 0;
    while (!out_valid0 && e < 20) begin @(posedge clk); e++; #1; end
    chk("latency", 32'(e), 4);
    drain;
    group(0, {8'd25, 8'd92, 8'd3, 8'd8}, {8'd3, 2'd2, 8'd8, 2'd3, 8'd25, 2'd0, 8'd92, 2'd1}, 0);
    group(0, {8'd1, 8'd4, 8'd3, 8'd2}, {8'd1, 2'd0, 8'd2, 2'd3, 8'd3, 2'd2, 8'd4, 2'd1}, 0);
    drain;
    group(0, {8'd5, 8'd5, 8'd1, 8'd5}, {8'd1, 2'd2, 8'd5, 2'd0, 8'd5, 2'd1, 8'd5, 2'd3}, 0);
    group(1, {8'd32, 8'd0, 8'd79, 8'd64}, {8'd79, 2'd2, 8'd64, 2'd3, 8'd32, 2'd0, 8'd0, 2'd1}, 0);
    drain;
    stall_en = 1;
    group(0, {8'd9, 8'd9, 8'd0, 8'd255}, {8'd0, 2'd2, 8'd9, 2'd0, 8'd9, 2'd1, 8'd255, 2'd3}, 1);
    drain;
    stall_en = 0;
    for (int i = 0; i < 4; i++) send(0, 8'(10 * (i + 1)), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 0;
    #1;
    chk("midrst_out_valid", 32'(out_valid0), 0);
    chk("midrst_busy", 32'(busy0), 0);
    chk("midrst_in_ready", 32'(in_ready0), 1);
    chk("midrst_out_data", 32'({out_data0, out_idx0}), 0);
    @(negedge clk);
    rst_n = 1;
    group(0, {8'd7, 8'd6, 8'd5, 8'd4}, {8'd4, 2'd3, 8'd5, 2'd2, 8'd6, 2'd1, 8'd7, 2'd0}, 0);
    drain;
    group(0, {8'd200, 8'd100, 8'd150, 8'd50}, {8'd50, 2'd3, 8'd100, 2'd1, 8'd150, 2'd2, 8'd200, 2'd0}, 0);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!busy0) break;
      in_valid0 = 1;
      in_data0  = 8'($urandom);
    end
    in_valid0 = 0;
    drain;
    chk("q0_empty", 32'(q0.size()), 0);
    chk("q1_empty", 32'(q1.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
